// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    ZERO
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on magnitudes; purely combinational.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   r_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] m_in,
  output logic [WIDTH:0]   r_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             borrow;

  // One extra bit above the shifted remainder makes the borrow the diff MSB.
  assign shifted = {r_in, q_in[WIDTH-1]};
  assign diff    = shifted - {2'b00, m_in};
  assign borrow  = diff[WIDTH+1];

  assign r_out = borrow ? shifted[WIDTH:0] : diff[WIDTH:0];
  assign q_out = {q_in[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divider with MIPS div semantics: quotient on lo, remainder on hi.
// Define DIV_UNSIGNED_EN to add the is_unsigned input (MIPS divu behaviour).
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : $clog2(WIDTH) + 1;

  div_state_t       state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             signed_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   step_r;
  logic [WIDTH-1:0] step_q;

`ifdef DIV_UNSIGNED_EN
  assign signed_op = ~is_unsigned;
`else
  assign signed_op = 1'b1;
`endif

  // The most-negative operand negates to itself, which is its correct unsigned magnitude.
  assign a_neg = signed_op & dividend[WIDTH-1];
  assign b_neg = signed_op & divisor[WIDTH-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor : divisor;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .r_in (r_q),
    .q_in (q_q),
    .m_in (m_q),
    .r_out(step_r),
    .q_out(step_q)
  );

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    q_d        = q_q;
    m_d        = m_q;
    cnt_d      = cnt_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    case (state_q)
      IDLE: begin
        // The done cycle is still IDLE, but a start there must not launch a new op.
        if (start && !done_q) begin
          busy_d     = 1'b1;
          div_zero_d = 1'b0;
          if (divisor == '0) begin
            state_d = ZERO;
          end else begin
            state_d = RUN;
            q_d     = a_mag;
            m_d     = b_mag;
            r_d     = '0;
            cnt_d   = '0;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
          end
        end
      end
      RUN: begin
        r_d   = step_r;
        q_d   = step_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        lo_d    = qneg_q ? -q_q : q_q;
        hi_d    = rneg_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      ZERO: begin
        done_d     = 1'b1;
        div_zero_d = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      r_q        <= '0;
      q_q        <= '0;
      m_q        <= '0;
      cnt_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      q_q        <= q_d;
      m_q        <= m_d;
      cnt_q      <= cnt_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: cycle-level reference model plus literal result checks.
module tb_div_seq;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
`ifdef DIV_UNSIGNED_EN
  logic         is_unsigned;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  div_seq #(.WIDTH(W)) dut (
    .clock      (clk),
    .reset_n    (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
`ifdef DIV_UNSIGNED_EN
    .is_unsigned(is_unsigned),
`endif
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: truncating signed division, remainder follows the dividend.
  task automatic predict(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q_out, output logic [W-1:0] r_out);
    longint sa, sb, qq, rr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    qq = sa / sb;
    rr = sa % sb;
    q_out = qq[W-1:0];
    r_out = rr[W-1:0];
  endtask

  // Cycle-level model: outputs derived from op acceptance and fixed latencies.
  logic         m_busy, m_done, m_dz;
  logic [W-1:0] m_hi, m_lo, p_lo, p_hi;
  logic         p_zero;
  int           m_cnt;

  initial begin
    m_busy = 0; m_done = 0; m_dz = 0; m_hi = '0; m_lo = '0;
    p_lo = '0; p_hi = '0; p_zero = 0; m_cnt = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 0; m_done = 0; m_dz = 0; m_hi = '0; m_lo = '0; m_cnt = 0;
      end else begin
        logic prev_done;
        prev_done = m_done;
        m_done = 0;
        if (m_cnt != 0) begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_done = 1;
            m_busy = 0;
            if (p_zero) m_dz = 1;
            else begin
              m_lo = p_lo;
              m_hi = p_hi;
            end
          end
        end else if (start && !prev_done) begin
          m_busy = 1;
          m_dz   = 0;
          p_zero = (divisor == '0);
          m_cnt  = p_zero ? 1 : W + 1;
          if (!p_zero) predict(dividend, divisor, p_lo, p_hi);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
      check("cyc_done", {31'b0, done}, {31'b0, m_done});
      check("cyc_dz", {31'b0, div_zero}, {31'b0, m_dz});
      check("cyc_hi", hi, m_hi);
      check("cyc_lo", lo, m_lo);
    end
  end

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi,
                        input logic exp_dz, input int exp_lat, input int exp_busy);
    int lat, nbusy;
    bit seen;
    @(negedge clk);
    start = 1; dividend = a; divisor = b;
    lat = 0; nbusy = 0; seen = 0;
    while (lat < 60 && !seen) begin
      @(negedge clk);
      start = 0;
      lat++;
      if (busy) nbusy++;
      if (done) seen = 1;
    end
    check({name, "_done_seen"}, {31'b0, seen}, 32'd1);
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_busy_cycles"}, nbusy, exp_busy);
    check({name, "_lo"}, lo, exp_lo);
    check({name, "_hi"}, hi, exp_hi);
    check({name, "_dz"}, {31'b0, div_zero}, {31'b0, exp_dz});
    $display("[TB] op %s: %h / %h -> lo=%h hi=%h dz=%b lat=%0d", name, a, b, lo, hi, div_zero, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, ndone;
    bit seen;
    rst_n = 0; start = 0; dividend = '0; divisor = '0;
`ifdef DIV_UNSIGNED_EN
    is_unsigned = 0;
`endif
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_dz", {31'b0, div_zero}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    rst_n = 1;

    run_op("t1_100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 33);
    run_op("t4_div0", 32'd5, 32'd0, 32'd14, 32'd2, 1'b1, 2, 1);
    repeat (3) @(negedge clk);
    check("t4_dz_hold", {31'b0, div_zero}, 32'd1);
    run_op("t4_9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34, 33);
    run_op("t2_m100_7", 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 34, 33);
    run_op("t2_100_m7", 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0, 34, 33);
    run_op("t3_min_m1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 34, 33);
    run_op("t3_min_1", 32'h80000000, 32'd1, 32'h80000000, 32'd0, 1'b0, 34, 33);
    run_op("zero_dvd", 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 34, 33);
    run_op("small_3_m10", 32'd3, 32'hFFFFFFF6, 32'd0, 32'd3, 1'b0, 34, 33);
    run_op("small_m3_10", 32'hFFFFFFFD, 32'd10, 32'd0, 32'hFFFFFFFD, 1'b0, 34, 33);
    run_op("min_min", 32'h80000000, 32'h80000000, 32'd1, 32'd0, 1'b0, 34, 33);

    // Test 5: asynchronous reset in the middle of a run.
    @(negedge clk);
    start = 1; dividend = 32'd100; divisor = 32'd7;
    @(negedge clk);
    start = 0;
    repeat (10) @(posedge clk);
    #3 rst_n = 0;
    #1;
    check("t5_busy", {31'b0, busy}, 32'd0);
    check("t5_done", {31'b0, done}, 32'd0);
    check("t5_hi", hi, 32'd0);
    check("t5_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1;
    run_op("t5_50_5", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 34, 33);

    // Test 6: start pulses while busy and in the done cycle are ignored.
    @(negedge clk);
    start = 1; dividend = 32'd100; divisor = 32'd7;
    lat = 0; ndone = 0; seen = 0;
    while (lat < 60 && !seen) begin
      @(negedge clk);
      start = 0;
      lat++;
      if (lat == 5) begin
        start = 1; dividend = 32'd9; divisor = 32'd3;
      end
      if (done) begin
        seen = 1;
        ndone++;
        start = 1; dividend = 32'd9; divisor = 32'd3;
      end
    end
    check("t6_latency", lat, 34);
    check("t6_lo", lo, 32'd14);
    check("t6_hi", hi, 32'd2);
    @(negedge clk);
    start = 0;
    if (busy) ndone += 100;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
      if (busy) ndone += 100;
    end
    check("t6_done_pulses", ndone, 1);
    check("t6_lo_final", lo, 32'd14);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
